// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU_control codes, ALUOp encodings and MIPS funct values.
// Used by the issue stage and by the ALU's own testbench.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_RSVD   = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NAND = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct to ALU_control translation, flagging encodings the ALU
// cannot execute.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op_e'(alu_op))
      ALUOP_MEM:    ctrl = ALU_ADD;
      ALUOP_BRANCH: ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  ctrl = ALU_ADD;
          FUNCT_SUB:  ctrl = ALU_SUB;
          FUNCT_AND:  ctrl = ALU_AND;
          FUNCT_OR:   ctrl = ALU_OR;
          FUNCT_NOR:  ctrl = ALU_NOR;
          FUNCT_SLT:  ctrl = ALU_SLT;
          FUNCT_NAND: ctrl = ALU_NAND;
          default:    illegal = 1'b1;
        endcase
      end
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the ripple ALU: decodes ops at enqueue, buffers them in a
// small FIFO and presents the head entry directly to the ALU inputs.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_alu_op,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [3:0]        alu_ctrl,
  output logic              err_illegal,
  output logic [CNT_W-1:0]  err_count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic       accept;
  logic       push;
  logic       pop;

  alu_ctrl_decode u_decode (
    .alu_op  (in_alu_op),
    .funct   (in_funct),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Ready is a pure function of registered state so the producer never sees a
  // combinational path from out_ready.
  assign in_ready  = (count != (PTR_W+1)'(DEPTH)) & rst_n;
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready & ~flush;
  assign push      = accept & ~dec_illegal;
  assign pop       = out_valid & out_ready & ~flush;

  assign alu_src1 = mem[rd_ptr].src1;
  assign alu_src2 = mem[rd_ptr].src2;
  assign alu_ctrl = mem[rd_ptr].ctrl;

  // NOTE: storage is reset because the ALU sees it directly and must read zero
  // out of reset; this is cheap only because DEPTH is tiny.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{ctrl: dec_ctrl, src1: in_src1, src2: in_src2};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flush gates accept, so illegal ops in a flush cycle are never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      err_illegal <= accept & dec_illegal;
      if (accept && dec_illegal && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_alu_op = 2'b00;
  logic [5:0]        in_funct = 6'b0;
  logic [DATA_W-1:0] in_src1 = '0;
  logic [DATA_W-1:0] in_src2 = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [3:0]        alu_ctrl;
  logic              err_illegal;
  logic [CNT_W-1:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_op   (in_alu_op),
    .in_funct    (in_funct),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_ctrl    (alu_ctrl),
    .err_illegal (err_illegal),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of buffered ops and a saturating error tally.
  typedef struct {
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
  } op_t;

  op_t m_q[$];
  int  m_errs  = 0;
  bit  m_pulse = 0;

  function automatic bit model_decode(input logic [1:0] op, input logic [5:0] fn,
                                      output logic [3:0] ctrl);
    ctrl = 4'b0000;
    if (op == 2'b00) begin ctrl = 4'b0010; return 1; end
    if (op == 2'b01) begin ctrl = 4'b0110; return 1; end
    if (op != 2'b10) return 0;
    if (fn == 6'b100000) begin ctrl = 4'b0010; return 1; end
    if (fn == 6'b100010) begin ctrl = 4'b0110; return 1; end
    if (fn == 6'b100100) begin ctrl = 4'b0000; return 1; end
    if (fn == 6'b100101) begin ctrl = 4'b0001; return 1; end
    if (fn == 6'b100111) begin ctrl = 4'b1100; return 1; end
    if (fn == 6'b101010) begin ctrl = 4'b0111; return 1; end
    if (fn == 6'b100110) begin ctrl = 4'b1101; return 1; end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_errs  = 0;
      m_pulse = 0;
    end else if (flush) begin
      m_q.delete();
      m_pulse = 0;
    end else begin
      logic [3:0] c;
      bit ok;
      bit acc;
      bit deq;
      acc = in_valid && (m_q.size() != DEPTH);
      deq = out_ready && (m_q.size() != 0);
      ok  = model_decode(in_alu_op, in_funct, c);
      m_pulse = acc && !ok;
      if (m_pulse && m_errs < 255) m_errs++;
      if (deq) void'(m_q.pop_front());
      if (acc && ok) m_q.push_back('{ctrl: c, s1: in_src1, s2: in_src2});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    check("cyc_in_ready", 64'(in_ready), 64'(rst_n && (m_q.size() != DEPTH)));
    check("cyc_err_illegal", 64'(err_illegal), 64'(m_pulse));
    check("cyc_err_count", 64'(err_count), 64'(m_errs));
    if (m_q.size() != 0) begin
      check("cyc_alu_ctrl", 64'(alu_ctrl), 64'(m_q[0].ctrl));
      check("cyc_alu_src1", 64'(alu_src1), 64'(m_q[0].s1));
      check("cyc_alu_src2", 64'(alu_src2), 64'(m_q[0].s2));
    end
  end

  // Apply inputs now (just after an edge), then advance one clock.
  task automatic step(input bit v, input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit rdy, input bit fl);
    in_valid  = v;
    in_alu_op = op;
    in_funct  = fn;
    in_src1   = a;
    in_src2   = b;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(0, 2'b00, 6'b0, 0, 0, rdy, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 0);
    check("rst_alu_src1", 64'(alu_src1), 0);
    check("rst_err_count", 64'(err_count), 0);
    rst_n = 1'b1;
    idle(1);
    check("post_rst_in_ready", 64'(in_ready), 1);

    // Single R-type add, immediate drain
    step(1, 2'b10, 6'b100000, 5, 7, 1, 0);
    check("add_out_valid", 64'(out_valid), 1);
    check("add_ctrl", 64'(alu_ctrl), 4'b0010);
    check("add_result", 64'(alu_src1 + alu_src2), 12);
    idle(1);
    check("add_drained", 64'(out_valid), 0);

    // Fill with out_ready low, third op stalls, then drain in order
    step(1, 2'b00, 6'b0, 1, 2, 0, 0);
    step(1, 2'b01, 6'b0, 3, 4, 0, 0);
    check("full_in_ready", 64'(in_ready), 0);
    check("full_head_ctrl", 64'(alu_ctrl), 4'b0010);
    step(1, 2'b10, 6'b101010, 9, 8, 0, 0);
    check("stall_head_src1", 64'(alu_src1), 1);
    step(1, 2'b10, 6'b101010, 9, 8, 1, 0);
    check("drain1_ctrl", 64'(alu_ctrl), 4'b0110);
    step(1, 2'b10, 6'b101010, 9, 8, 1, 0);
    check("slt_ctrl", 64'(alu_ctrl), 4'b0111);
    check("slt_src2", 64'(alu_src2), 8);
    idle(1);
    check("drain_empty", 64'(out_valid), 0);

    // Illegal ops back-to-back, then one dropped by flush
    step(1, 2'b10, 6'b000000, 1, 1, 1, 0);
    check("ill1_pulse", 64'(err_illegal), 1);
    check("ill1_valid", 64'(out_valid), 0);
    step(1, 2'b11, 6'b100000, 1, 1, 1, 0);
    check("ill2_pulse", 64'(err_illegal), 1);
    check("ill2_count", 64'(err_count), 2);
    step(1, 2'b11, 6'b0, 1, 1, 1, 1);
    check("ill_flush_pulse", 64'(err_illegal), 0);
    check("ill_flush_count", 64'(err_count), 2);

    // Nand extension decodes
    step(1, 2'b10, 6'b100110, 6, 3, 1, 0);
    check("nand_ctrl", 64'(alu_ctrl), 4'b1101);

    // Saturation: 2 + 300 illegal ops clamps at 255
    for (int i = 0; i < 300; i++) step(1, 2'b11, 6'b0, 0, 0, 1, 0);
    idle(1);
    check("sat_count", 64'(err_count), 255);
    check("sat_pulse_off", 64'(err_illegal), 0);

    // Flush with FIFO full while a legal op is offered and head is taken
    step(1, 2'b00, 6'b0, 10, 11, 0, 0);
    step(1, 2'b01, 6'b0, 12, 13, 0, 0);
    check("pre_flush_full", 64'(in_ready), 0);
    in_valid = 1;
    step(1, 2'b00, 6'b0, 20, 21, 1, 1);
    check("flush_out_valid", 64'(out_valid), 0);
    check("flush_in_ready", 64'(in_ready), 1);
    check("flush_keeps_errs", 64'(err_count), 255);
    idle(1);
    check("flush_discarded", 64'(out_valid), 0);

    // Streaming sub/nor alternating with out_ready high: no bubbles
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 2'b01, 6'b0, 32'(i), 32'(i + 100), 1, 0);
      else            step(1, 2'b10, 6'b100111, 32'(i), 32'(i + 100), 1, 0);
      check("stream_valid", 64'(out_valid), 1);
      check("stream_ctrl", 64'(alu_ctrl), (i % 2 == 0) ? 4'b0110 : 4'b1100);
      check("stream_src1", 64'(alu_src1), 64'(i));
    end
    idle(1);

    // Asynchronous reset with one entry held
    step(1, 2'b10, 6'b100101, 44, 55, 0, 0);
    check("hold_valid", 64'(out_valid), 1);
    check("hold_ctrl", 64'(alu_ctrl), 4'b0001);
    in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 0);
    check("arst_alu_ctrl", 64'(alu_ctrl), 0);
    check("arst_err_count", 64'(err_count), 0);
    check("arst_in_ready", 64'(in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check("post_arst_ready", 64'(in_ready), 1);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
